ir_blob_decoder: RTL and testbench

IR_BLOB_DECODER -- requirements
Module: ir_blob_decoder

---
 rtl/ir_blob_decoder_pkg.sv | 41 ++++
 rtl/ir_blob_decoder.sv | 134 +++++++++++++
 tb/tb_ir_blob_decoder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ir_blob_decoder_pkg.sv
// Shared camera definitions for the IR blob decoder: FSM encoding, the
// not-found marker and the layout of the packed high-bits/size byte.
package ir_blob_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        B0   = 3'd2,
        B1   = 3'd3,
        B2   = 3'd4
    } state_t;

    // A blob whose X and Y both read back as this value is an empty slot.
    localparam logic [9:0] NOT_FOUND_COORD = 10'd1023;

    localparam int PK_Y_HI    = 7;
    localparam int PK_Y_LO    = 6;
    localparam int PK_X_HI    = 5;
    localparam int PK_X_LO    = 4;
    localparam int PK_SIZE_HI = 3;
    localparam int PK_SIZE_LO = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] size;
        logic       found;
    } blob_t;

    function automatic blob_t decode_blob(input logic [7:0] x_lo,
                                          input logic [7:0] y_lo,
                                          input logic [7:0] pk);
        blob_t b;
        b.x     = {pk[PK_X_HI:PK_X_LO], x_lo};
        b.y     = {pk[PK_Y_HI:PK_Y_LO], y_lo};
        b.size  = pk[PK_SIZE_HI:PK_SIZE_LO];
        b.found = !((b.x == NOT_FOUND_COORD) && (b.y == NOT_FOUND_COORD));
        return b;
    endfunction

endpackage

// File: rtl/ir_blob_decoder.sv
// Decodes the camera's blob report byte stream into per-blob strobes and
// keeps the last cleanly completed frame's blob 0 position.
module ir_blob_decoder
    import ir_blob_decoder_pkg::*;
#(
    parameter int HEADER_BYTES = 1,
    parameter int NUM_BLOBS    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic [9:0] blob_x,
    output logic [9:0] blob_y,
    output logic [3:0] blob_size,
    output logic [1:0] blob_idx,
    output logic       blob_found,
    output logic       blob_stb,
    output logic       frame_done,
    output logic       frame_error,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       pos_valid
);

    localparam logic [1:0] HDR_LAST    = 2'((HEADER_BYTES == 0) ? 0 : HEADER_BYTES - 1);
    localparam logic [1:0] LAST_BLOB   = 2'(NUM_BLOBS - 1);
    localparam state_t     START_STATE = (HEADER_BYTES == 0) ? B0 : HDR;

    state_t     state, state_nxt;
    logic [1:0] hdr_cnt, blob_cnt;
    logic [7:0] x_lo, y_lo;
    logic [9:0] b0_x, b0_y;
    logic       b0_found;
    blob_t      blob_cur;
    logic       accept, take_b2, take_last;
    logic       p_found;
    logic [9:0] p_x, p_y;

    // frame_start wins over data_valid, so a byte in the start cycle is dropped.
    assign accept    = data_valid && !frame_start;
    assign take_b2   = accept && (state == B2);
    assign take_last = take_b2 && (blob_cnt == LAST_BLOB);
    assign blob_cur  = decode_blob(x_lo, y_lo, data_in);

    // Blob 0 of a single-blob frame is still in flight when the frame ends.
    assign p_found = (blob_cnt == 2'd0) ? blob_cur.found : b0_found;
    assign p_x     = (blob_cnt == 2'd0) ? blob_cur.x     : b0_x;
    assign p_y     = (blob_cnt == 2'd0) ? blob_cur.y     : b0_y;

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        if (frame_start) begin
            state_nxt = START_STATE;
        end else if (data_valid) begin
            case (state)
                IDLE:    state_nxt = IDLE;
                HDR:     if (hdr_cnt == HDR_LAST) state_nxt = B0;
                B0:      state_nxt = B1;
                B1:      state_nxt = B2;
                B2:      state_nxt = (blob_cnt == LAST_BLOB) ? IDLE : B0;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: non-blocking everywhere here so every register samples pre-edge values.
            hdr_cnt     <= '0;
            blob_cnt    <= '0;
            x_lo        <= '0;
            y_lo        <= '0;
            b0_x        <= '0;
            b0_y        <= '0;
            b0_found    <= 1'b0;
            blob_x      <= '0;
            blob_y      <= '0;
            blob_size   <= '0;
            blob_idx    <= '0;
            blob_found  <= 1'b0;
            blob_stb    <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            pos_x       <= '0;
            pos_y       <= '0;
            pos_valid   <= 1'b0;
        end else begin
            blob_stb    <= take_b2;
            frame_done  <= take_last;
            frame_error <= frame_start && (state != IDLE);

            if (frame_start) begin
                hdr_cnt  <= '0;
                blob_cnt <= '0;
            end else if (accept) begin
                case (state)
                    HDR: hdr_cnt <= hdr_cnt + 2'd1;
                    B0:  x_lo    <= data_in;
                    B1:  y_lo    <= data_in;
                    B2: begin
                        blob_x     <= blob_cur.x;
                        blob_y     <= blob_cur.y;
                        blob_size  <= blob_cur.size;
                        blob_found <= blob_cur.found;
                        blob_idx   <= blob_cnt;
                        blob_cnt   <= take_last ? 2'd0 : blob_cnt + 2'd1;
                        if (blob_cnt == 2'd0) begin
                            b0_x     <= blob_cur.x;
                            b0_y     <= blob_cur.y;
                            b0_found <= blob_cur.found;
                        end
                        if (take_last) begin
                            pos_valid <= p_found;
                            if (p_found) begin
                                pos_x <= p_x;
                                pos_y <= p_y;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_blob_decoder.sv
// Directed bench for ir_blob_decoder: a cycle-exact vector table for one
// clean frame, then hand-written gap, abort, empty, drop and reset sequences.
module tb_ir_blob_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic [7:0] data_in;
    logic       data_valid;
    logic [9:0] blob_x, blob_y, pos_x, pos_y;
    logic [3:0] blob_size;
    logic [1:0] blob_idx;
    logic       blob_found, blob_stb, frame_done, frame_error, pos_valid;

    int n_vec  = 0;
    int n_miss = 0;

    ir_blob_decoder #(.HEADER_BYTES(1), .NUM_BLOBS(4)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .data_in(data_in),
        .data_valid(data_valid), .blob_x(blob_x), .blob_y(blob_y),
        .blob_size(blob_size), .blob_idx(blob_idx), .blob_found(blob_found),
        .blob_stb(blob_stb), .frame_done(frame_done), .frame_error(frame_error),
        .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] size;
        logic       found;
    } exp_blob_t;

    typedef struct {
        logic        fs;
        logic        dv;
        logic [7:0]  din;
        logic [50:0] exp;
    } vec_t;

    localparam logic [9:0] X0 = 10'd421;
    localparam logic [9:0] Y0 = 10'd707;
    localparam logic [9:0] NF = 10'd1023;

    function automatic logic [50:0] pack_out(
        input logic stb, input logic done, input logic err, input logic [1:0] idx,
        input logic found, input logic [3:0] size, input logic [9:0] x, input logic [9:0] y,
        input logic pv, input logic [9:0] px, input logic [9:0] py);
        return {stb, done, err, idx, found, size, x, y, pv, px, py};
    endfunction

    function automatic logic [50:0] dut_out();
        return pack_out(blob_stb, frame_done, frame_error, blob_idx, blob_found,
                        blob_size, blob_x, blob_y, pos_valid, pos_x, pos_y);
    endfunction

    function automatic vec_t mk(input logic fs, input logic dv, input logic [7:0] din,
                                input logic [50:0] exp);
        vec_t v;
        v.fs = fs; v.dv = dv; v.din = din; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read one full period later.
    task automatic cyc(input logic fs, input logic dv, input logic [7:0] din);
        frame_start = fs;
        data_valid  = dv;
        data_in     = din;
        @(negedge clk);
    endtask

    task automatic play_frame(input string tag, input logic [7:0] b [13], input int gap,
                              input int start_mode, input exp_blob_t e [4],
                              input logic [20:0] pos_exp);
        if (start_mode == 1) cyc(1'b1, 1'b0, 8'h00);
        else if (start_mode == 2) cyc(1'b1, 1'b1, 8'h77);
        if (start_mode != 0)
            check($sformatf("%s/start", tag), 64'({blob_stb, frame_done, frame_error}), 64'd0);
        for (int i = 0; i < 13; i++) begin
            cyc(1'b0, 1'b1, b[i]);
            if (i > 0 && (i % 3) == 0) begin
                int k;
                k = i / 3 - 1;
                check($sformatf("%s/stb%0d", tag, k),
                      64'({blob_stb, frame_done, frame_error}), 64'({1'b1, k == 3, 1'b0}));
                check($sformatf("%s/blob%0d", tag, k),
                      64'({blob_idx, blob_found, blob_size, blob_x, blob_y}),
                      64'({2'(k), e[k].found, e[k].size, e[k].x, e[k].y}));
            end else begin
                check($sformatf("%s/byte%0d", tag, i),
                      64'({blob_stb, frame_done, frame_error}), 64'd0);
            end
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0, 1'b0, 8'h00);
                check($sformatf("%s/gap%0d_%0d", tag, i, g),
                      64'({blob_stb, frame_done, frame_error}), 64'd0);
            end
        end
        check($sformatf("%s/pos", tag), 64'({pos_valid, pos_x, pos_y}), 64'(pos_exp));
    endtask

    vec_t       tbl [16];
    logic [7:0] fr_std [13];
    logic [7:0] fr_b   [13];
    logic [7:0] fr_ff  [13];
    exp_blob_t  e_std [4];
    exp_blob_t  e_b   [4];
    exp_blob_t  e_ff  [4];

    initial begin
        fr_std = '{8'h00, 8'hA5, 8'hC3, 8'h95, 8'hFF, 8'hFF, 8'hFF,
                   8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        fr_b   = '{8'h00, 8'h10, 8'h20, 8'h6A, 8'hFF, 8'hFF, 8'hFF,
                   8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        fr_ff  = '{default: 8'hFF};
        e_std  = '{'{X0, Y0, 4'd5, 1'b1}, '{NF, NF, 4'd15, 1'b0},
                   '{NF, NF, 4'd15, 1'b0}, '{NF, NF, 4'd15, 1'b0}};
        e_b    = '{'{10'd528, 10'd288, 4'd10, 1'b1}, '{NF, NF, 4'd15, 1'b0},
                   '{NF, NF, 4'd15, 1'b0}, '{NF, NF, 4'd15, 1'b0}};
        e_ff   = '{default: '{NF, NF, 4'd15, 1'b0}};

        // One clean frame, cycle by cycle: stb, done, err, idx, found, size, x, y, pos.
        tbl[0]  = mk(1'b1, 1'b0, 8'h00, '0);
        tbl[1]  = mk(1'b0, 1'b1, 8'h00, '0);
        tbl[2]  = mk(1'b0, 1'b1, 8'hA5, '0);
        tbl[3]  = mk(1'b0, 1'b1, 8'hC3, '0);
        tbl[4]  = mk(1'b0, 1'b1, 8'h95, pack_out(1, 0, 0, 2'd0, 1, 4'd5, X0, Y0, 0, 10'd0, 10'd0));
        tbl[5]  = mk(1'b0, 1'b1, 8'hFF, pack_out(0, 0, 0, 2'd0, 1, 4'd5, X0, Y0, 0, 10'd0, 10'd0));
        tbl[6]  = mk(1'b0, 1'b1, 8'hFF, pack_out(0, 0, 0, 2'd0, 1, 4'd5, X0, Y0, 0, 10'd0, 10'd0));
        tbl[7]  = mk(1'b0, 1'b1, 8'hFF, pack_out(1, 0, 0, 2'd1, 0, 4'd15, NF, NF, 0, 10'd0, 10'd0));
        tbl[8]  = mk(1'b0, 1'b1, 8'hFF, pack_out(0, 0, 0, 2'd1, 0, 4'd15, NF, NF, 0, 10'd0, 10'd0));
        tbl[9]  = mk(1'b0, 1'b1, 8'hFF, pack_out(0, 0, 0, 2'd1, 0, 4'd15, NF, NF, 0, 10'd0, 10'd0));
        tbl[10] = mk(1'b0, 1'b1, 8'hFF, pack_out(1, 0, 0, 2'd2, 0, 4'd15, NF, NF, 0, 10'd0, 10'd0));
        tbl[11] = mk(1'b0, 1'b1, 8'hFF, pack_out(0, 0, 0, 2'd2, 0, 4'd15, NF, NF, 0, 10'd0, 10'd0));
        tbl[12] = mk(1'b0, 1'b1, 8'hFF, pack_out(0, 0, 0, 2'd2, 0, 4'd15, NF, NF, 0, 10'd0, 10'd0));
        tbl[13] = mk(1'b0, 1'b1, 8'hFF, pack_out(1, 1, 0, 2'd3, 0, 4'd15, NF, NF, 1, X0, Y0));
        tbl[14] = mk(1'b0, 1'b0, 8'h00, pack_out(0, 0, 0, 2'd3, 0, 4'd15, NF, NF, 1, X0, Y0));
        tbl[15] = mk(1'b0, 1'b1, 8'h55, pack_out(0, 0, 0, 2'd3, 0, 4'd15, NF, NF, 1, X0, Y0));

        reset = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("reset_state", 64'(dut_out()), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].fs, tbl[i].dv, tbl[i].din);
            check($sformatf("tbl%0d", i), 64'(dut_out()), 64'(tbl[i].exp));
        end

        play_frame("gap3", fr_std, 3, 1, e_std, {1'b1, X0, Y0});

        // Abort in the middle of blob 1, then let the restarted frame complete.
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'hA5);
        cyc(1'b0, 1'b1, 8'hC3);
        cyc(1'b0, 1'b1, 8'h95);
        check("abort/stb0", 64'({blob_stb, blob_idx}), 64'({1'b1, 2'd0}));
        cyc(1'b0, 1'b1, 8'hFF);
        check("abort/b0_byte", 64'({blob_stb, frame_done, frame_error}), 64'd0);
        cyc(1'b1, 1'b0, 8'h00);
        check("abort/error", 64'({blob_stb, frame_done, frame_error}), 64'({3'b001}));
        check("abort/hold", 64'({blob_idx, blob_found, blob_x, blob_y}), 64'({2'd0, 1'b1, X0, Y0}));
        check("abort/pos", 64'({pos_valid, pos_x, pos_y}), 64'({1'b1, X0, Y0}));
        play_frame("restart", fr_b, 0, 0, e_b, {1'b1, 10'd528, 10'd288});

        play_frame("allff", fr_ff, 0, 1, e_ff, {1'b0, 10'd528, 10'd288});
        play_frame("drop77", fr_std, 0, 2, e_std, {1'b1, X0, Y0});

        // Reset while the decoder sits in B1.
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'hA5);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 8'hC3);
        check("rst_mid/outputs", 64'(dut_out()), 64'd0);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 8'h95);
        check("rst_mid/idle_byte", 64'(dut_out()), 64'd0);
        cyc(1'b0, 1'b0, 8'h00);
        check("rst_mid/quiet", 64'(dut_out()), 64'd0);
        play_frame("post_rst", fr_b, 1, 1, e_b, {1'b1, 10'd528, 10'd288});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
